// File: rtl/bash_fetch.sv
// rtl/bash_fetch.sv - bias byte loader and per-group packed bias word server
//
// Loads a layer's bias bytes from a byte stream, packs every eight bytes into
// a 64-bit group word ([63:32] 3x3 biases, [31:0] 1x1 biases, MSB byte =
// lowest channel) and serves one word per output-channel group.
//
// Ports:
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   layer_start_i  pulse: start loading a new layer (abandons any load)
//   num_groups_i   groups in layer minus 1, sampled on layer_start_i
//   bias_data_i    bias byte, stream order group 0 byte 0 .. byte 7, group 1 ..
//   bias_valid_i   bias_data_i valid
//   bias_ready_o   byte accepted when bias_valid_i & bias_ready_o
//   group_rst_i    pulse: point back to group 0 (wins over group_next_i)
//   group_next_i   pulse: advance to next group, wrapping after num_groups
//   bash_2_o       packed bias word for the current group
//   bash_valid_o   bash_2_o holds a valid word
//   load_done_o    pulse when the last byte of the layer has been written
module bash_fetch #(
  parameter int MAX_GROUPS = 16,
  parameter int GRP_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             layer_start_i,
  input  logic [GRP_W-1:0] num_groups_i,
  input  logic [7:0]       bias_data_i,
  input  logic             bias_valid_i,
  output logic             bias_ready_o,
  input  logic             group_rst_i,
  input  logic             group_next_i,
  output logic [63:0]      bash_2_o,
  output logic             bash_valid_o,
  output logic             load_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       byte_cnt;
  logic [GRP_W-1:0] grp_cnt;
  logic [GRP_W-1:0] num_groups_q;
  logic [GRP_W-1:0] rd_ptr;
  logic [GRP_W-1:0] ptr_adv;
  // Only the first seven bytes of a group need holding; the eighth arrives
  // live on bias_data_i when the word is written.
  logic [55:0]      pack_q;
  logic [63:0]      pack_next;
  logic [63:0]      buffer [MAX_GROUPS];
  logic             accept;
  logic             word_done;
  logic             last_byte;

  assign accept    = (state_q == LOAD) && bias_valid_i && bias_ready_o;
  assign pack_next = {pack_q, bias_data_i};
  assign word_done = accept && (byte_cnt == 3'd7);
  assign last_byte = word_done && (grp_cnt == num_groups_q);
  assign ptr_adv   = (rd_ptr == num_groups_q) ? '0 : rd_ptr + GRP_W'(1);

  always_comb begin
    state_d = state_q;
    if (layer_start_i) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (last_byte) state_d = SERVE;
        default: state_d = state_q;
      endcase
    end
  end

  // Buffer contents survive reset; only written on a completed group word.
  always_ff @(posedge clk_i) begin
    if (word_done) buffer[grp_cnt] <= pack_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      byte_cnt     <= '0;
      grp_cnt      <= '0;
      num_groups_q <= '0;
      rd_ptr       <= '0;
      pack_q       <= '0;
      bias_ready_o <= 1'b0;
      bash_2_o     <= '0;
      bash_valid_o <= 1'b0;
      load_done_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_o <= 1'b0;
      if (layer_start_i) begin
        num_groups_q <= num_groups_i;
        byte_cnt     <= '0;
        grp_cnt      <= '0;
        bash_valid_o <= 1'b0;
        bias_ready_o <= 1'b1;
      end else begin
        case (state_q)
          LOAD: begin
            if (accept) begin
              pack_q   <= pack_next[55:0];
              byte_cnt <= byte_cnt + 3'd1;
              if (word_done) grp_cnt <= grp_cnt + GRP_W'(1);
              if (last_byte) begin
                bias_ready_o <= 1'b0;
                load_done_o  <= 1'b1;
              end
            end
          end
          SERVE: begin
            // load_done_o is high only in the first SERVE cycle, so it
            // doubles as the entry marker for the initial group-0 read.
            if (load_done_o || group_rst_i) begin
              rd_ptr       <= '0;
              bash_2_o     <= buffer[0];
              bash_valid_o <= 1'b1;
            end else if (group_next_i) begin
              rd_ptr   <= ptr_adv;
              bash_2_o <= buffer[ptr_adv];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bash_fetch.sv
// tb/tb_bash_fetch.sv - scoreboard testbench for bash_fetch
module tb_bash_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        layer_start;
  logic [3:0]  num_groups;
  logic [7:0]  bias_data;
  logic        bias_valid;
  logic        bias_ready;
  logic        group_rst;
  logic        group_next;
  logic [63:0] bash_2;
  logic        bash_valid;
  logic        load_done;

  always #5 clk = ~clk;

  bash_fetch #(.MAX_GROUPS(16), .GRP_W(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .layer_start_i (layer_start),
    .num_groups_i  (num_groups),
    .bias_data_i   (bias_data),
    .bias_valid_i  (bias_valid),
    .bias_ready_o  (bias_ready),
    .group_rst_i   (group_rst),
    .group_next_i  (group_next),
    .bash_2_o      (bash_2),
    .bash_valid_o  (bash_valid),
    .load_done_o   (load_done)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim_bytes[$];
  logic [63:0] mbuf[16];
  int          mptr = 0;
  int          mng  = 0;
  logic        pulse_prev = 1'b0;
  logic        valid_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a new word is presented when valid rises or after a group pulse.
  always @(posedge clk) pulse_prev <= group_next | group_rst;

  always @(negedge clk) begin
    if (bash_valid && (!valid_prev || pulse_prev)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", bash_2);
      end else begin
        chk("bash_word", bash_2, exp_q.pop_front());
      end
    end
    valid_prev = bash_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bytes(input int n, input bit ramp, input int base);
    stim_bytes.delete();
    for (int i = 0; i < n; i++)
      stim_bytes.push_back(ramp ? 8'(base + i) : 8'($urandom));
  endtask

  // mode: 0 always valid, 1 valid every other cycle, 2 random stalls.
  task automatic load(input int ng, input int mode, input bit noise);
    int total;
    int idx;
    int cyc;
    bit done;
    bit v;
    bit acc;
    layer_start = 1'b1;
    num_groups  = 4'(ng);
    tick();
    layer_start = 1'b0;
    chk("start_valid", {63'd0, bash_valid}, 64'd0);
    chk("start_ready", {63'd0, bias_ready}, 64'd1);
    total = (ng + 1) * 8;
    idx = 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom % 3) != 0;
      endcase
      bias_valid = v;
      bias_data  = v ? stim_bytes[idx] : 8'($urandom);
      group_next = noise ? 1'($urandom) : 1'b0;
      group_rst  = noise ? 1'($urandom) : 1'b0;
      acc = v && bias_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx == total) done = 1'b1;
      end
    end
    bias_valid = 1'b0;
    group_next = 1'b0;
    group_rst  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL load_timeout actual=%0d required=%0d", idx, total);
    end
    chk("load_done_pulse", {63'd0, load_done}, 64'd1);
    chk("ready_drop", {63'd0, bias_ready}, 64'd0);
    for (int g = 0; g <= ng; g++)
      mbuf[g] = {stim_bytes[8*g], stim_bytes[8*g+1], stim_bytes[8*g+2], stim_bytes[8*g+3],
                 stim_bytes[8*g+4], stim_bytes[8*g+5], stim_bytes[8*g+6], stim_bytes[8*g+7]};
    mptr = 0;
    mng  = ng;
    exp_q.push_back(mbuf[0]);
    tick();
    chk("load_done_single", {63'd0, load_done}, 64'd0);
    chk("serve_valid", {63'd0, bash_valid}, 64'd1);
  endtask

  task automatic pulse(input bit nx, input bit rs);
    group_next = nx;
    group_rst  = rs;
    if (rs) mptr = 0;
    else if (nx) mptr = (mptr == mng) ? 0 : mptr + 1;
    if (rs || nx) exp_q.push_back(mbuf[mptr]);
    tick();
    group_next = 1'b0;
    group_rst  = 1'b0;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
    chk("hold_word", bash_2, mbuf[mptr]);
    chk("hold_ready", {63'd0, bias_ready}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    layer_start = 1'b0;
    num_groups  = '0;
    bias_data   = '0;
    bias_valid  = 1'b0;
    group_rst   = 1'b0;
    group_next  = 1'b0;
    tick();
    chk("rst_ready", {63'd0, bias_ready}, 64'd0);
    chk("rst_valid", {63'd0, bash_valid}, 64'd0);
    chk("rst_done", {63'd0, load_done}, 64'd0);
    chk("rst_word", bash_2, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single group, bytes 01..08.
    fill_bytes(8, 1'b1, 1);
    load(0, 0, 1'b0);
    #4;
    chk("t2_word", bash_2, 64'h0102030405060708);
    tick();

    // Three groups with every-other-cycle stalls, then wrap.
    fill_bytes(24, 1'b1, 0);
    load(2, 1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("t3_wrap", bash_2, 64'h0001020304050607);

    // rst and next together from group 1: rst wins.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    chk("t4_rst_wins", bash_2, 64'h0001020304050607);
    hold(5);

    // Reset mid-load after 5 bytes.
    layer_start = 1'b1;
    num_groups  = 4'd0;
    tick();
    layer_start = 1'b0;
    bias_valid  = 1'b1;
    repeat (5) begin
      bias_data = 8'($urandom);
      tick();
    end
    bias_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'd0, bias_ready}, 64'd0);
    chk("mid_rst_valid", {63'd0, bash_valid}, 64'd0);
    chk("mid_rst_done", {63'd0, load_done}, 64'd0);
    chk("mid_rst_word", bash_2, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fill_bytes(8, 1'b0, 0);
    load(0, 0, 1'b0);
    hold(2);

    // layer_start during SERVE with pulse noise during the load.
    fill_bytes(16, 1'b0, 0);
    load(1, 2, 1'b1);
    pulse(1'b1, 1'b0);
    hold(3);

    // Full-depth layer: walk to group 15 then wrap.
    fill_bytes(128, 1'b0, 0);
    load(15, 2, 1'b0);
    repeat (15) pulse(1'b1, 1'b0);
    chk("t6_group15", bash_2, mbuf[15]);
    pulse(1'b1, 1'b0);
    chk("t6_wrap", bash_2, mbuf[0]);

    // Randomized layers and pulse sequences.
    for (int it = 0; it < 5; it++) begin
      int ng;
      ng = $urandom_range(0, 15);
      fill_bytes((ng + 1) * 8, 1'b0, 0);
      load(ng, $urandom_range(0, 2), 1'($urandom));
      for (int p = 0; p < 24; p++) pulse(1'($urandom), ($urandom % 5) == 0);
      hold($urandom_range(1, 4));
    end

    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
